// File: rtl/scalar_result_writeback_pkg.sv
// Shared constants and slot-entry type for the scalar result writeback stage.
package scalar_result_writeback_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned UNIT_W = 3;
  localparam int unsigned NUM_S  = 8;

  localparam logic [UNIT_W-1:0] UNIT_LOG  = 3'd0;
  localparam logic [UNIT_W-1:0] UNIT_SHF  = 3'd1;
  localparam logic [UNIT_W-1:0] UNIT_ADD  = 3'd2;
  localparam logic [UNIT_W-1:0] UNIT_POP  = 3'd3;
  localparam logic [UNIT_W-1:0] UNIT_XFER = 3'd4;

  localparam int unsigned LAT_LOG_DEF  = 1;
  localparam int unsigned LAT_SHF_DEF  = 2;
  localparam int unsigned LAT_ADD_DEF  = 3;
  localparam int unsigned LAT_POP_DEF  = 4;
  localparam int unsigned LAT_XFER     = 1;
  localparam int unsigned MAX_LAT_DEF  = 4;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    logic [UNIT_W-1:0] unit;
    logic [DATA_W-1:0] xfer_data;
  } slot_t;

  function automatic logic unit_legal(input logic [UNIT_W-1:0] unit);
    return unit <= UNIT_XFER;
  endfunction

endpackage

// File: rtl/scalar_wb_slot_pipe.sv
// Completion slot pipe: entries shift toward index 0 each cycle; index 0 is
// the entry completing this cycle. A push lands at its index after the shift.
module scalar_wb_slot_pipe
  import scalar_result_writeback_pkg::*;
#(
  parameter int unsigned MAX_LAT = MAX_LAT_DEF,
  localparam int unsigned IDX_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [IDX_W-1:0] slot_idx_i,
  input  slot_t            push_entry_i,
  output logic             slot_free_c_o,
  output slot_t            head_o
);

  slot_t slot_q  [MAX_LAT];
  slot_t slot_d  [MAX_LAT];
  slot_t shifted [MAX_LAT];

  // Pipe contents after this cycle's shift; the top entry refills empty.
  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) shifted[i] = '0;
    for (int i = 0; i < MAX_LAT - 1; i++) shifted[i] = slot_q[i+1];
  end

  // Is the requested post-shift slot free (no result-port collision)?
  always_comb begin
    slot_free_c_o = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (slot_idx_i == IDX_W'(i)) slot_free_c_o = ~shifted[i].valid;
    end
  end

  // Next pipe state: shifted contents plus an optional new entry.
  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) slot_d[i] = shifted[i];
    if (push_i) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (slot_idx_i == IDX_W'(i)) slot_d[i] = push_entry_i;
      end
    end
  end

  // Slot register; reset discards every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LAT; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign head_o = slot_q[0];

endmodule

// File: rtl/scalar_result_writeback.sv
// Scalar result writeback: S register file, operand read ports, reservation
// bits and fixed-latency completion tracking for the scalar functional units.
// Optional: define SCALAR_WB_BYPASS_EN to forward writeback data to read
// ports in the completion cycle.
module scalar_result_writeback
  import scalar_result_writeback_pkg::*;
#(
  parameter int unsigned LAT_LOG = LAT_LOG_DEF,
  parameter int unsigned LAT_SHF = LAT_SHF_DEF,
  parameter int unsigned LAT_ADD = LAT_ADD_DEF,
  parameter int unsigned LAT_POP = LAT_POP_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_issue,
  input  logic [2:0]  i_unit,
  input  logic [2:0]  i_dest,
  input  logic [63:0] i_xfer_data,
  input  logic [63:0] i_log_res,
  input  logic [63:0] i_shf_res,
  input  logic [63:0] i_add_res,
  input  logic [63:0] i_pop_res,
  input  logic [2:0]  i_i,
  input  logic [2:0]  i_j,
  input  logic [2:0]  i_k,
  output logic [63:0] o_si,
  output logic [63:0] o_sj,
  output logic [63:0] o_sk,
  output logic        o_issue_ready,
  output logic        o_issue_err,
  output logic [7:0]  o_s_busy,
  output logic        o_wb_valid,
  output logic [2:0]  o_wb_dest,
  output logic [63:0] o_wb_data
);

  localparam int unsigned IDX_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [DATA_W-1:0] s_q [NUM_S];
  logic [NUM_S-1:0]  busy_q, busy_d;
  logic              err_q;
  logic [IDX_W-1:0]  lat_idx;
  logic              slot_free;
  slot_t             push_entry;
  slot_t             head;

  // Post-shift slot index (latency - 1) for the requested unit.
  always_comb begin
    lat_idx = '0;
    case (i_unit)
      UNIT_LOG:  lat_idx = IDX_W'(LAT_LOG - 1);
      UNIT_SHF:  lat_idx = IDX_W'(LAT_SHF - 1);
      UNIT_ADD:  lat_idx = IDX_W'(LAT_ADD - 1);
      UNIT_POP:  lat_idx = IDX_W'(LAT_POP - 1);
      UNIT_XFER: lat_idx = IDX_W'(LAT_XFER - 1);
      default:   lat_idx = '0;
    endcase
  end

  assign o_issue_ready = i_issue & unit_legal(i_unit) & ~busy_q[i_dest] & slot_free;

  // Entry recorded for an accepted issue.
  always_comb begin
    push_entry           = '0;
    push_entry.valid     = 1'b1;
    push_entry.dest      = i_dest;
    push_entry.unit      = i_unit;
    push_entry.xfer_data = i_xfer_data;
  end

  scalar_wb_slot_pipe #(
    .MAX_LAT (MAX_LAT)
  ) u_slot_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (o_issue_ready),
    .slot_idx_i    (lat_idx),
    .push_entry_i  (push_entry),
    .slot_free_c_o (slot_free),
    .head_o        (head)
  );

  // Result mux: pick the completing unit's bus as sampled this cycle.
  always_comb begin
    o_wb_data = '0;
    if (head.valid) begin
      case (head.unit)
        UNIT_LOG:  o_wb_data = i_log_res;
        UNIT_SHF:  o_wb_data = i_shf_res;
        UNIT_ADD:  o_wb_data = i_add_res;
        UNIT_POP:  o_wb_data = i_pop_res;
        UNIT_XFER: o_wb_data = head.xfer_data;
        default:   o_wb_data = '0;
      endcase
    end
  end

  assign o_wb_valid = head.valid;
  assign o_wb_dest  = head.dest;

  // Reservation bits: clear on completion, set on accept (never the same reg).
  always_comb begin
    busy_d = busy_q;
    if (head.valid)    busy_d[head.dest] = 1'b0;
    if (o_issue_ready) busy_d[i_dest]    = 1'b1;
  end

  // Register array, busy bits and the reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_S; i++) s_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (head.valid) s_q[head.dest] <= o_wb_data;
      busy_q <= busy_d;
      err_q  <= i_issue & ~o_issue_ready;
    end
  end

  assign o_s_busy    = busy_q;
  assign o_issue_err = err_q;

  // Operand read ports, optionally forwarding the completing result.
  always_comb begin
    o_si = s_q[i_i];
    o_sj = s_q[i_j];
    o_sk = s_q[i_k];
`ifdef SCALAR_WB_BYPASS_EN
    if (o_wb_valid && (i_i == o_wb_dest)) o_si = o_wb_data;
    if (o_wb_valid && (i_j == o_wb_dest)) o_sj = o_wb_data;
    if (o_wb_valid && (i_k == o_wb_dest)) o_sk = o_wb_data;
`endif
  end

endmodule
